// File: rtl/game_hud_text_if.sv
// Character lookup bus between the video front end, the font/map ROM and the HUD overlay.
// The overlay sits on the slave side: it produces the ROM address and the final glyph.
interface game_hud_text_if #(
   parameter int AW = 12
);
   logic [4:0]    h_ascii;
   logic [4:0]    v_ascii;
   logic [AW-1:0] rom_addr;
   logic [7:0]    rom_ascii;
   logic [7:0]    cur_ascii;

   modport master (output h_ascii, output v_ascii, input rom_addr, output rom_ascii, input cur_ascii);
   modport slave  (input h_ascii, input v_ascii, output rom_addr, input rom_ascii, output cur_ascii);
endinterface

// File: rtl/game_hud_text.sv
// HUD sidebar text overlay: converts numeric fields to BCD once per frame and
// substitutes score digits, life glyph and username over the ROM character map.
module game_hud_text_chk #(
   parameter int              COLS        = 20,
   parameter int              ROWS        = 30,
   parameter int              AW          = 12,
   parameter int              NF          = 3,
   parameter int              D           = 3,
   parameter logic [NF*AW-1:0] FIELD_ADDR = {12'h238, 12'h211, 12'h199},
   parameter int              NU          = 3,
   parameter logic [AW-1:0]   NAME_ADDR   = 12'h0e4,
   parameter int              NAME_STRIDE = 2
) (
   input logic       clk,
   input logic       rst,
   input logic [4:0] h_ascii,
   input logic [4:0] v_ascii,
   input logic       busy,
   input logic       conv_done
);
   function automatic bit ranges_ok();
      bit ok;
      int na;
      int fa;
      ok = 1'b1;
      for (int f = 0; f < NF; f++) begin
         for (int k = 0; k < NU; k++) begin
            na = int'(NAME_ADDR) + k * NAME_STRIDE;
            fa = int'(FIELD_ADDR[f*AW +: AW]);
            if ((na >= fa) && (na < fa + D)) ok = 1'b0;
         end
      end
      return ok;
   endfunction

   localparam bit RANGES_OK = ranges_ok();

   a_ranges_disjoint: assert property (@(posedge clk) disable iff (rst) RANGES_OK);
   a_done_not_busy:   assert property (@(posedge clk) disable iff (rst) conv_done |-> !busy);
   a_col_range:       assert property (@(posedge clk) disable iff (rst) {27'd0, h_ascii} < 32'(COLS));
   a_row_range:       assert property (@(posedge clk) disable iff (rst) {27'd0, v_ascii} < 32'(ROWS));
endmodule

module game_hud_text #(
   parameter int               COLS        = 20,
   parameter int               ROWS        = 30,
   parameter int               AW          = 12,
   parameter int               NF          = 3,
   parameter int               W           = 10,
   parameter int               D           = 3,
   parameter logic [NF*AW-1:0] FIELD_ADDR  = {12'h238, 12'h211, 12'h199},
   parameter logic [AW-1:0]    LIFE_ADDR   = 12'h138,
   parameter int               NU          = 3,
   parameter logic [AW-1:0]    NAME_ADDR   = 12'h0e4,
   parameter int               NAME_STRIDE = 2,
   parameter bit               LZ          = 1'b0,
   parameter int               BLINK       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   game_hud_text_if.slave    bus,
   input  logic [NF*W-1:0]   field_val,
   input  logic [3:0]        life,
   input  logic              mode,
   input  logic [8*NU-1:0]   username,
   output logic              busy,
   output logic              conv_done,
   output logic              overrun
);
   localparam int FW = (NF > 1) ? $clog2(NF) : 1;
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int BW = $clog2(2 * BLINK);
   localparam int DB = 4 * D;
   localparam logic [DB-1:0] NINES = {D{4'h9}};

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, NEXT = 2'd3} state_t;

   state_t            state_r;
   logic              busy_r;
   logic              conv_done_r;
   logic              overrun_r;
   logic [NF*W-1:0]   snap_r;
   logic [FW-1:0]     fld_r;
   logic [FW-1:0]     nxt_idx_s;
   logic [CW-1:0]     cnt_r;
   logic [W-1:0]      bin_r;
   logic [DB-1:0]     bcd_r;
   logic [DB-1:0]     dd_adj_s;
   logic              ovf_r;
   logic [NF*DB-1:0]  shadow_r;
   logic [NF*DB-1:0]  disp_r;
   logic [BW-1:0]     blink_r;
   logic [7:0]        cur_ascii_r;
   logic [AW-1:0]     rom_addr_s;
   logic [3:0]        dig_s;
   logic              zrun_s;
   logic              blank_s;
   logic              match_s;
   logic              field_hit_s;
   logic [7:0]        field_glyph_s;
   logic              name_hit_s;
   logic [7:0]        name_glyph_s;
   logic [7:0]        life_glyph_s;
   logic [7:0]        glyph_s;

   assign rom_addr_s    = AW'(bus.v_ascii) * AW'(COLS) + AW'(bus.h_ascii);
   assign bus.rom_addr  = rom_addr_s;
   assign bus.cur_ascii = cur_ascii_r;
   assign busy          = busy_r;
   assign conv_done     = conv_done_r;
   assign overrun       = overrun_r;
   assign nxt_idx_s     = fld_r + FW'(1'b1);

   // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
   always_comb begin
      dd_adj_s = bcd_r;
      for (int n = 0; n < D; n++) begin
         if (bcd_r[4*n +: 4] >= 4'd5) dd_adj_s[4*n +: 4] = bcd_r[4*n +: 4] + 4'd3;
         else                         dd_adj_s[4*n +: 4] = bcd_r[4*n +: 4];
      end
   end

   // Conversion sequencer; any bit pushed out of the top nibble means the value needs more than D digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         busy_r      <= 1'b0;
         conv_done_r <= 1'b0;
         overrun_r   <= 1'b0;
         snap_r      <= '0;
         fld_r       <= '0;
         cnt_r       <= '0;
         bin_r       <= '0;
         bcd_r       <= '0;
         ovf_r       <= 1'b0;
         shadow_r    <= '0;
      end else begin
         conv_done_r <= 1'b0;
         if (frame_start && (state_r != IDLE)) overrun_r <= 1'b1;
         case (state_r)
            IDLE: begin
               if (frame_start) begin
                  state_r <= LOAD;
                  busy_r  <= 1'b1;
               end
            end
            LOAD: begin
               snap_r  <= field_val;
               fld_r   <= '0;
               bin_r   <= field_val[W-1:0];
               bcd_r   <= '0;
               cnt_r   <= '0;
               ovf_r   <= 1'b0;
               state_r <= SHIFT;
            end
            SHIFT: begin
               bcd_r <= {dd_adj_s[DB-2:0], bin_r[W-1]};
               bin_r <= {bin_r[W-2:0], 1'b0};
               ovf_r <= ovf_r | dd_adj_s[DB-1];
               if (cnt_r == CW'(W-1)) state_r <= NEXT;
               else                   cnt_r   <= cnt_r + CW'(1'b1);
            end
            NEXT: begin
               shadow_r[fld_r*DB +: DB] <= ovf_r ? NINES : bcd_r;
               if (fld_r == FW'(NF-1)) begin
                  state_r     <= IDLE;
                  busy_r      <= 1'b0;
                  conv_done_r <= 1'b1;
               end else begin
                  fld_r   <= nxt_idx_s;
                  bin_r   <= snap_r[nxt_idx_s*W +: W];
                  bcd_r   <= '0;
                  cnt_r   <= '0;
                  ovf_r   <= 1'b0;
                  state_r <= SHIFT;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Glyph selection for the current address; field ranges are disjoint so matches can be OR-merged.
   always_comb begin
      dig_s         = 4'd0;
      zrun_s        = 1'b1;
      blank_s       = 1'b0;
      match_s       = 1'b0;
      field_hit_s   = 1'b0;
      field_glyph_s = 8'h00;
      name_hit_s    = 1'b0;
      name_glyph_s  = 8'h00;
      for (int f = 0; f < NF; f++) begin
         zrun_s = 1'b1;
         for (int j = 0; j < D; j++) begin
            dig_s         = disp_r[f*DB + 4*(D-1-j) +: 4];
            zrun_s        = zrun_s & (dig_s == 4'd0);
            blank_s       = LZ && (j < D-1) && zrun_s;
            match_s       = (rom_addr_s == FIELD_ADDR[f*AW +: AW] + AW'(j));
            field_hit_s   = field_hit_s | match_s;
            field_glyph_s = field_glyph_s | ({8{match_s}} & (blank_s ? 8'h20 : {4'h3, dig_s}));
         end
      end
      for (int k = 0; k < NU; k++) begin
         match_s      = (rom_addr_s == NAME_ADDR + AW'(k * NAME_STRIDE));
         name_hit_s   = name_hit_s | match_s;
         name_glyph_s = name_glyph_s | ({8{match_s}} & username[8*k +: 8]);
      end
      if (mode == 1'b0)                                 life_glyph_s = 8'h02;
      else if ((life == 4'd1) && (blink_r >= BW'(BLINK))) life_glyph_s = 8'h20;
      else                                              life_glyph_s = 8'h30 + {4'h0, life};
      if (field_hit_s)                    glyph_s = field_glyph_s;
      else if (rom_addr_s == LIFE_ADDR)   glyph_s = life_glyph_s;
      else if (name_hit_s)                glyph_s = name_glyph_s;
      else                                glyph_s = bus.rom_ascii;
   end

   // Display bank, blink phase and the registered output glyph.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_r      <= '0;
         blink_r     <= '0;
         cur_ascii_r <= 8'h00;
      end else begin
         if (conv_done_r) disp_r <= shadow_r;
         if (frame_start) blink_r <= (blink_r == BW'(2*BLINK-1)) ? '0 : blink_r + BW'(1'b1);
         cur_ascii_r <= glyph_s;
      end
   end

   game_hud_text_chk #(
      .COLS(COLS), .ROWS(ROWS), .AW(AW), .NF(NF), .D(D), .FIELD_ADDR(FIELD_ADDR),
      .NU(NU), .NAME_ADDR(NAME_ADDR), .NAME_STRIDE(NAME_STRIDE)
   ) u_chk (
      .clk(clk), .rst(rst), .h_ascii(bus.h_ascii), .v_ascii(bus.v_ascii),
      .busy(busy_r), .conv_done(conv_done_r)
   );
endmodule

// File: tb/tb_game_hud_text.sv
// Directed bench for game_hud_text: one default-style instance (BLINK=2) and one with leading-zero blanking.
module tb_game_hud_text;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic [29:0] field_val = 30'd0;
   logic [3:0]  life = 4'd0;
   logic        mode = 1'b0;
   logic [23:0] username = "CBA";
   logic        busy0, done0, ovr0, busy1, done1, ovr1;
   logic [7:0]  c0, c1;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          lat;
   int          n_done;

   localparam int LIFE = 12'h138;

   game_hud_text_if #(.AW(12)) bus0 ();
   game_hud_text_if #(.AW(12)) bus1 ();

   game_hud_text #(.BLINK(2)) u_dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .bus(bus0),
      .field_val(field_val), .life(life), .mode(mode), .username(username),
      .busy(busy0), .conv_done(done0), .overrun(ovr0)
   );

   game_hud_text #(.LZ(1'b1)) u_lz (
      .clk(clk), .rst(rst), .frame_start(frame_start), .bus(bus1),
      .field_val(field_val), .life(life), .mode(mode), .username(username),
      .busy(busy1), .conv_done(done1), .overrun(ovr1)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic rd(input int addr, input logic [7:0] rom, output logic [7:0] g0, output logic [7:0] g1);
      bus0.h_ascii = 5'(addr % 20);
      bus0.v_ascii = 5'(addr / 20);
      bus1.h_ascii = 5'(addr % 20);
      bus1.v_ascii = 5'(addr / 20);
      bus0.rom_ascii = rom;
      bus1.rom_ascii = rom;
      @(posedge clk); #1;
      g0 = bus0.cur_ascii;
      g1 = bus1.cur_ascii;
   endtask

   task automatic chk_digits(input string tag, input bit lz_inst, input int base, input logic [23:0] exp);
      logic [7:0] g0, g1;
      for (int j = 0; j < 3; j++) begin
         rd(base + j, 8'h00, g0, g1);
         chk_eq($sformatf("%s[%0d]", tag, j), lz_inst ? g1 : g0, exp[23-8*j -: 8]);
      end
   endtask

   task automatic pulse();
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
   endtask

   task automatic run_frame(output int cycles);
      pulse();
      chk_eq("busy_after_start", busy0, 1'b1);
      cycles = 0;
      while ((cycles < 100) && !done0) begin
         @(posedge clk); #1;
         cycles++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus0.h_ascii = 5'd0; bus0.v_ascii = 5'd0; bus0.rom_ascii = 8'h00;
      bus1.h_ascii = 5'd0; bus1.v_ascii = 5'd0; bus1.rom_ascii = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_busy", busy0, 1'b0);
      chk_eq("rst_done", done0, 1'b0);
      chk_eq("rst_overrun", ovr0, 1'b0);
      chk_eq("rst_cur_ascii", bus0.cur_ascii, 8'h00);
      rst = 1'b0;
      chk_digits("rst_disp", 1'b0, 12'h199, "000");
      chk_digits("rst_disp_lz", 1'b1, 12'h199, {8'h20, 8'h20, "0"});

      bus0.h_ascii = 5'd9; bus0.v_ascii = 5'd20; #1;
      chk_eq("rom_addr", bus0.rom_addr, 12'h199);

      field_val = {10'd45, 10'd500, 10'd123};
      run_frame(lat);
      chk_eq("conv_latency", lat, 34);
      chk_eq("done_one_cycle", done0, 1'b0);
      chk_eq("no_overrun", ovr0, 1'b0);
      chk_digits("f0_123", 1'b0, 12'h199, "123");
      chk_digits("f1_500", 1'b0, 12'h211, "500");
      chk_digits("f2_045", 1'b0, 12'h238, "045");

      field_val = {10'd0, 10'd50, 10'd7};
      run_frame(lat);
      chk_digits("f0_007", 1'b0, 12'h199, "007");
      chk_digits("lz_f0_7", 1'b1, 12'h199, {8'h20, 8'h20, "7"});
      chk_digits("lz_f1_50", 1'b1, 12'h211, {8'h20, "50"});
      chk_digits("lz_f2_0", 1'b1, 12'h238, {8'h20, 8'h20, "0"});

      field_val = {10'd1000, 10'd999, 10'd1023};
      run_frame(lat);
      chk_digits("ovf_1023", 1'b0, 12'h199, "999");
      chk_digits("val_999", 1'b0, 12'h211, "999");
      chk_digits("ovf_1000", 1'b0, 12'h238, "999");

      field_val = {10'd9, 10'd80, 10'd321};
      pulse();
      repeat (4) @(posedge clk);
      #1 field_val = {10'd3, 10'd2, 10'd1};
      frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      n_done = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (done0) n_done++;
      end
      chk_eq("overrun_done_count", n_done, 1);
      chk_eq("overrun_flag", ovr0, 1'b1);
      chk_digits("ovr_f0", 1'b0, 12'h199, "321");
      chk_digits("ovr_f1", 1'b0, 12'h211, "080");
      chk_digits("ovr_f2", 1'b0, 12'h238, "009");

      mode = 1'b0; life = 4'd3;
      rd(LIFE, 8'h00, c0, c1);
      chk_eq("life_endless", c0, 8'h02);
      mode = 1'b1;
      rd(LIFE, 8'h00, c0, c1);
      chk_eq("life_3", c0, "3");

      rd(12'h0e4, 8'h00, c0, c1);
      chk_eq("name_0", c0, "A");
      rd(12'h0e6, 8'h00, c0, c1);
      chk_eq("name_1", c0, "B");
      rd(12'h0e8, 8'h00, c0, c1);
      chk_eq("name_2", c0, "C");
      rd(12'h0e5, 8'h77, c0, c1);
      chk_eq("name_gap_rom", c0, 8'h77);
      rd(12'h000, 8'h5a, c0, c1);
      chk_eq("pass_000", c0, 8'h5a);
      rd(12'h19c, 8'h41, c0, c1);
      chk_eq("pass_after_field", c0, 8'h41);
      rd(12'h198, 8'h42, c0, c1);
      chk_eq("pass_before_field", c0, 8'h42);

      field_val = {10'd45, 10'd500, 10'd123};
      run_frame(lat);
      pulse();
      repeat (9) @(posedge clk);
      #1;
      chk_eq("busy_before_rst", busy0, 1'b1);
      rst = 1'b1;
      #1;
      chk_eq("rst_mid_busy", busy0, 1'b0);
      chk_eq("rst_mid_cur", bus0.cur_ascii, 8'h00);
      chk_eq("rst_mid_overrun", ovr0, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      n_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done0) n_done++;
      end
      chk_eq("rst_mid_no_done", n_done, 0);
      chk_digits("rst_mid_f0", 1'b0, 12'h199, "000");
      chk_digits("rst_mid_f2", 1'b0, 12'h238, "000");

      mode = 1'b1; life = 4'd1;
      rd(LIFE, 8'h00, c0, c1);
      chk_eq("blink_0", c0, "1");
      run_frame(lat);
      rd(LIFE, 8'h00, c0, c1);
      chk_eq("blink_1", c0, "1");
      run_frame(lat);
      rd(LIFE, 8'h00, c0, c1);
      chk_eq("blink_2", c0, 8'h20);
      chk_eq("blink_2_long_period", c1, "1");
      run_frame(lat);
      rd(LIFE, 8'h00, c0, c1);
      chk_eq("blink_3", c0, 8'h20);
      run_frame(lat);
      rd(LIFE, 8'h00, c0, c1);
      chk_eq("blink_wrap", c0, "1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
